// File: rtl/multicycle_control.sv
// multicycle_control
// Main controller for a multi-cycle MIPS core with a shared instruction/data
// memory. Walks each instruction through fetch, decode, execute, memory and
// write-back states, stalls on the memory ready handshake, and counts
// retired instructions.
//
// Control outputs are decoded from the state register. The FETCH strobes
// ir_write and pc_write are also qualified by mem_ready in the same cycle.
// Every output is gated by rst_n, so it drops to zero the moment reset is
// asserted, without waiting for a clock edge.
module multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic [1:0]       pc_source,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             illegal_op,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC     = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [3:0]       state_r;
   logic [CNT_W-1:0] count_r;

   // True for the opcodes this controller knows how to sequence.
   function automatic logic op_is_legal(input logic [5:0] op);
      logic legal;
      case (op)
         OP_RTYPE, OP_J, OP_BEQ, OP_LW, OP_SW: legal = 1'b1;
         default:                              legal = 1'b0;
      endcase
      return legal;
   endfunction

   // State sequencing and the retired-instruction counter; a retire is every
   // entry into FETCH from a final instruction state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_FETCH;
         count_r <= '0;
      end else begin
         case (state_r)
            S_FETCH: begin
               if (mem_ready) begin
                  state_r <= S_DECODE;
               end else begin
                  state_r <= S_FETCH;
               end
            end
            S_DECODE: begin
               case (opcode)
                  OP_LW, OP_SW: state_r <= S_MEM_ADDR;
                  OP_RTYPE:     state_r <= S_EXEC;
                  OP_BEQ:       state_r <= S_BRANCH;
                  OP_J:         state_r <= S_JUMP;
                  default:      state_r <= S_FETCH;
               endcase
            end
            S_MEM_ADDR: begin
               if (opcode == OP_LW) begin
                  state_r <= S_MEM_RD;
               end else begin
                  state_r <= S_MEM_WR;
               end
            end
            S_MEM_RD: begin
               if (mem_ready) begin
                  state_r <= S_MEM_WB;
               end else begin
                  state_r <= S_MEM_RD;
               end
            end
            S_MEM_WB: begin
               state_r <= S_FETCH;
               count_r <= count_r + CNT_ONE;
            end
            S_MEM_WR: begin
               if (mem_ready) begin
                  state_r <= S_FETCH;
                  count_r <= count_r + CNT_ONE;
               end else begin
                  state_r <= S_MEM_WR;
               end
            end
            S_EXEC: begin
               state_r <= S_R_WB;
            end
            S_R_WB, S_BRANCH, S_JUMP: begin
               state_r <= S_FETCH;
               count_r <= count_r + CNT_ONE;
            end
            default: begin
               // Unused encodings recover to FETCH without retiring anything.
               state_r <= S_FETCH;
            end
         endcase
      end
   end

   // Moore decode of the control word; everything held at zero during reset.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = PCSRC_ALU;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      alu_op        = ALU_ADD;
      illegal_op    = 1'b0;
      if (!rst_n) begin
         // Reset overrides every strobe, including the mem_ready-gated ones.
         illegal_op = 1'b0;
      end else begin
         case (state_r)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = SRCB_FOUR;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE: begin
               alu_src_b  = SRCB_IMM_SH;
               illegal_op = ~op_is_legal(opcode);
            end
            S_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
               mem_to_reg = 1'b1;
               reg_write  = 1'b1;
               reg_dst    = 1'b0;
            end
            S_MEM_WR: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            S_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
               reg_dst   = 1'b1;
               reg_write = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = ALU_SUB;
               pc_write_cond = 1'b1;
               pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
               pc_write  = 1'b1;
               pc_source = PCSRC_JUMP;
            end
            default: begin
               // Unused encodings drive nothing for their single cycle.
               pc_write = 1'b0;
            end
         endcase
      end
   end

   // Debug view of the state and the retired count.
   always_comb begin
      state       = state_r;
      instr_count = count_r;
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is described
// by its opcode and the stall cycles the memory inserts. The reference model
// expands that into the expected state path and the control word of every
// cycle. A narrow counter is used so the retired count wraps during the
// random run.
module tb_multicycle_control;

   localparam int CNT_W = 4;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       illegal_op;
   } ctl_t;

   logic             clk;
   logic             rst_n;
   logic [5:0]       opcode;
   logic             mem_ready;
   logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic             reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
   logic [1:0]       pc_source, alu_src_b, alu_op;
   logic [3:0]       state;
   logic [CNT_W-1:0] instr_count;
   ctl_t             obs_ctl;

   int checks   = 0;
   int failures = 0;
   int model_count = 0;

   multicycle_control #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .illegal_op(illegal_op), .state(state),
      .instr_count(instr_count)
   );

   assign obs_ctl = '{pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                      ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                      alu_op, illegal_op};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic legal(input logic [5:0] op);
      return op inside {6'd0, 6'd2, 6'd4, 6'd35, 6'd43};
   endfunction

   // Control word the specification lists for a state, given the inputs.
   function automatic ctl_t exp_ctl(input int st, input logic rdy, input logic [5:0] op);
      ctl_t c;
      c = '0;
      case (st)
         0: begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
         1: begin c.alu_src_b = 2'b11; c.illegal_op = ~legal(op); end
         2: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         3: begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
         4: begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
         5: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
         6: begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
         7: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
         8: begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
         9: begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
         default: c = '0;
      endcase
      return c;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check at the falling edge, advance past the rising edge.
   task automatic step(input int exp_st, input logic rdy, input logic [5:0] op);
      mem_ready = rdy;
      opcode    = op;
      @(negedge clk);
      check($sformatf("state(exp %0d)", exp_st), 32'(state), 32'(exp_st));
      check($sformatf("ctl(state %0d)", exp_st), 32'(obs_ctl), 32'(exp_ctl(exp_st, rdy, op)));
      @(posedge clk);
      #1;
   endtask

   // Expand one instruction into its cycle path and check the retired count afterwards.
   task automatic run_instr(input logic [5:0] op, input int fetch_waits, input int mem_waits);
      int ms;
      for (int i = 0; i < fetch_waits; i++) step(0, 1'b0, 6'($urandom));
      step(0, 1'b1, 6'($urandom));
      step(1, 1'($urandom), op);
      if (op == 6'd35 || op == 6'd43) begin
         step(2, 1'($urandom), op);
         ms = (op == 6'd35) ? 3 : 5;
         for (int i = 0; i < mem_waits; i++) step(ms, 1'b0, op);
         step(ms, 1'b1, op);
         if (op == 6'd35) step(4, 1'($urandom), op);
      end else if (op == 6'd0) begin
         step(6, 1'($urandom), op);
         step(7, 1'($urandom), op);
      end else if (op == 6'd4) begin
         step(8, 1'($urandom), op);
      end else if (op == 6'd2) begin
         step(9, 1'($urandom), op);
      end
      if (legal(op)) model_count = (model_count + 1) % (1 << CNT_W);
      check("instr_count", 32'(instr_count), 32'(model_count));
   endtask

   initial begin
      logic [5:0] op;
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      opcode    = 6'd35;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", 32'(state), 32'd0);
      check("reset_ctl", 32'(obs_ctl), 32'd0);
      check("reset_count", 32'(instr_count), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed scenarios.
      run_instr(6'd35, 0, 0);
      run_instr(6'd43, 0, 3);
      run_instr(6'd0, 0, 0);
      run_instr(6'd4, 0, 0);
      run_instr(6'd2, 0, 0);
      run_instr(6'd13, 0, 0);
      run_instr(6'd0, 5, 0);

      // Random instruction mix with random stalls.
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 5))
            0: op = 6'd35;
            1: op = 6'd43;
            2: op = 6'd0;
            3: op = 6'd4;
            4: op = 6'd2;
            default: begin
               op = 6'($urandom);
               while (legal(op)) op = 6'($urandom);
            end
         endcase
         run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      // Asynchronous reset in the middle of a load.
      step(0, 1'b1, 6'($urandom));
      step(1, 1'b1, 6'd35);
      step(2, 1'b1, 6'd35);
      mem_ready = 1'b0;
      @(negedge clk);
      check("mid_state_before", 32'(state), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_reset_state", 32'(state), 32'd0);
      check("mid_reset_ctl", 32'(obs_ctl), 32'd0);
      check("mid_reset_count", 32'(instr_count), 32'd0);
      model_count = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_instr(6'd35, 0, 0);
      run_instr(6'd43, 1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute bound so a stuck run still ends.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle MIPS main controller. It sequences a shared-memory datapath (one memory for instructions and data, one ALU, PC/IR/A/B/ALUOut registers) through fetch, decode, execute, memory and write-back states. It replaces the single-cycle opcode decoder in the multi-cycle core and waits on a memory ready handshake. It also counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  instruction bits [31:26] from IR; stable from DECODE until the instruction ends
- mem_ready  in  1  memory has completed the current read or write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by ALU zero (datapath ANDs the two)
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- i_or_d  out  1  memory address select: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  1  write-register select: 1 rd, 0 rt
- mem_to_reg  out  1  write-data select: 1 MDR, 0 ALUOut
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  ALU A operand: 0 PC, 1 register A
- alu_src_b  out  2  ALU B operand: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate
- alu_op  out  2  00 add, 01 subtract, 10 use the funct field
- illegal_op  out  1  one-cycle pulse for an unknown opcode
- state  out  4  current state, for debug
- instr_count  out  CNT_W  number of retired instructions

## Operation
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9. Encodings 10–15 go to FETCH on the next edge with all outputs 0.
- Outputs are Moore decodes of the state, except ir_write and pc_write in FETCH, which are gated by mem_ready.
- Any output not listed for a state is 0.
- FETCH:
  - mem_read=1, alu_src_b=01.
  - When mem_ready=1: ir_write=1, pc_write=1, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_b=11. Next state by opcode:
  - 35 or 43 → MEM_ADDR
  - 0 → EXEC
  - 4 → BRANCH
  - 2 → JUMP
  - any other value → illegal_op=1, next state FETCH
- MEM_ADDR: alu_src_a=1, alu_src_b=10. Next state MEM_RD if opcode is 35, else MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Stay until mem_ready=1, then go to MEM_WB.
- MEM_WB: mem_to_reg=1, reg_write=1, reg_dst=0. Next state FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Stay until mem_ready=1, then go to FETCH.
- EXEC: alu_src_a=1, alu_op=10. Next state R_WB.
- R_WB: reg_dst=1, reg_write=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01. Next state FETCH.
- JUMP: pc_write=1, pc_source=10. Next state FETCH.
- instr_count increments by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH or JUMP. It wraps modulo 2^CNT_W. An illegal opcode does not increment it.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=FETCH, instr_count=0.
  - Every control output is forced to 0 while rst_n=0, including mem_read and the gated strobes.
- The first fetch request appears combinationally in the cycle rst_n goes high.
- Cycles per instruction with mem_ready held at 1: lw 5, sw 4, R-type 4, beq 3, j 3, illegal 2.
- Each cycle that mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_read and mem_write stay asserted for the whole wait and deassert the cycle after the cycle in which mem_ready=1 is sampled.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
- opcode is sampled only in DECODE and MEM_ADDR.
- rst_n asserted mid-instruction aborts immediately and returns to FETCH. instr_count clears; no partial increment.

## Test plan
- Reset then lw (opcode 35), mem_ready=1 throughout → states 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4. instr_count 0→1 after 5 cycles.
- sw (43), mem_ready=0 for 3 cycles in MEM_WR → mem_write high for 4 cycles. reg_write never asserted. 4+3=7 cycles total; instr_count +1.
- Sequence R-type (0), beq (4), j (2), all mem_ready=1 → 4+3+3=10 cycles. alu_op=10/01/00 in EXEC/BRANCH/DECODE. pc_source=01 in BRANCH, 10 in JUMP. instr_count=3.
- Opcode 13 (unsupported) → illegal_op high for exactly the DECODE cycle, back to FETCH. instr_count unchanged. No write strobe asserted.
- FETCH with mem_ready=0 for 5 cycles → ir_write=pc_write=0 and mem_read=1 throughout; a single-cycle ir_write/pc_write pulse when mem_ready rises.
- rst_n pulsed low in MEM_RD → outputs 0 and state=0 with no clock edge; instr_count=0. After release, a normal fetch completes in 1 cycle.
